// File: rtl/stopwatch_ascii.sv
// Tenths-of-a-second stopwatch (00.0..99.9) with ASCII digit outputs for the LCD stage.
// Optional lap hold is compiled in when STOPWATCH_LAP_EN is defined.
module stopwatch_ascii #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 10
) (
  input  logic       CLK,
  input  logic       btnr,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [7:0] d10,
  output logic [7:0] d1,
  output logic [7:0] d10ths,
  output logic       running,
  output logic       upd,
  output logic       ovf
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;

  typedef enum logic [0:0] {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Returns {carry, next digit}; an out-of-range digit is forced back to '0' without carry.
  function automatic logic [8:0] f_digit_inc(input logic [7:0] d);
    logic [8:0] res;
    if (d == ASCII_9) begin
      res = {1'b1, ASCII_0};
    end else if ((d < ASCII_0) || (d > ASCII_9)) begin
      res = {1'b0, ASCII_0};
    end else begin
      res = {1'b0, d + 8'd1};
    end
    return res;
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_running;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nxt;
  logic          w_tick;
  logic [7:0]    r_cnt10, r_cnt1, r_cnt10ths;
  logic [7:0]    w_cnt10_nxt, w_cnt1_nxt, w_cnt10ths_nxt;
  logic [8:0]    w_inc_h, w_inc_u, w_inc_t;
  logic          r_ovf;
  logic          w_ovf_nxt;
  logic          r_upd;
  logic [23:0]   w_disp_cur;
  logic [23:0]   w_disp_nxt;

  assign w_tick  = (r_state == ST_RUN) && (r_presc >= PRESC_MAX);
  assign w_inc_h = f_digit_inc(r_cnt10);
  assign w_inc_u = f_digit_inc(r_cnt1);
  assign w_inc_t = f_digit_inc(r_cnt10ths);

  // Start/stop state machine next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STOP: begin
        if (start_stop) w_state_nxt = ST_RUN;
        else            w_state_nxt = ST_STOP;
      end
      ST_RUN: begin
        if (start_stop) w_state_nxt = ST_STOP;
        else            w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_STOP;
    endcase
  end

  // Prescaler holds in STOP so a pause keeps the partial tick.
  always_comb begin
    if (clear) begin
      w_presc_nxt = {PW{1'b0}};
    end else if (w_tick) begin
      w_presc_nxt = {PW{1'b0}};
    end else if (r_state == ST_RUN) begin
      w_presc_nxt = r_presc + PW'(1);
    end else begin
      w_presc_nxt = r_presc;
    end
  end

  // Digit cascade; clear takes priority over a coincident tick.
  always_comb begin
    w_cnt10_nxt    = r_cnt10;
    w_cnt1_nxt     = r_cnt1;
    w_cnt10ths_nxt = r_cnt10ths;
    w_ovf_nxt      = r_ovf;
    if (clear) begin
      w_cnt10_nxt    = ASCII_0;
      w_cnt1_nxt     = ASCII_0;
      w_cnt10ths_nxt = ASCII_0;
      w_ovf_nxt      = 1'b0;
    end else if (w_tick) begin
      w_cnt10ths_nxt = w_inc_t[7:0];
      if (w_inc_t[8]) begin
        w_cnt1_nxt = w_inc_u[7:0];
        if (w_inc_u[8]) begin
          w_cnt10_nxt = w_inc_h[7:0];
          if (w_inc_h[8]) w_ovf_nxt = 1'b1;
          else            w_ovf_nxt = r_ovf;
        end else begin
          w_cnt10_nxt = r_cnt10;
        end
      end else begin
        w_cnt1_nxt = r_cnt1;
      end
    end else begin
      w_cnt10ths_nxt = r_cnt10ths;
    end
  end

  // Live count, prescaler, state and flags.
  always_ff @(posedge CLK) begin
    if (btnr) begin
      r_state    <= ST_STOP;
      r_running  <= 1'b0;
      r_presc    <= {PW{1'b0}};
      r_cnt10    <= ASCII_0;
      r_cnt1     <= ASCII_0;
      r_cnt10ths <= ASCII_0;
      r_ovf      <= 1'b0;
      r_upd      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= (w_state_nxt == ST_RUN);
      r_presc    <= w_presc_nxt;
      r_cnt10    <= w_cnt10_nxt;
      r_cnt1     <= w_cnt1_nxt;
      r_cnt10ths <= w_cnt10ths_nxt;
      r_ovf      <= w_ovf_nxt;
      r_upd      <= (w_disp_nxt != w_disp_cur);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic       r_hold;
  logic       w_hold_nxt;
  logic [7:0] r_disp10, r_disp1, r_disp10ths;

  // Lap hold toggles only in RUN; stopping or clearing releases it.
  always_comb begin
    if (clear) begin
      w_hold_nxt = 1'b0;
    end else if ((r_state == ST_RUN) && start_stop) begin
      w_hold_nxt = 1'b0;
    end else if ((r_state == ST_RUN) && lap) begin
      w_hold_nxt = ~r_hold;
    end else begin
      w_hold_nxt = r_hold;
    end
  end

  assign w_disp_cur = {r_disp10, r_disp1, r_disp10ths};
  assign w_disp_nxt = w_hold_nxt ? w_disp_cur : {w_cnt10_nxt, w_cnt1_nxt, w_cnt10ths_nxt};

  // Displayed digits track the live count unless held.
  always_ff @(posedge CLK) begin
    if (btnr) begin
      r_hold      <= 1'b0;
      r_disp10    <= ASCII_0;
      r_disp1     <= ASCII_0;
      r_disp10ths <= ASCII_0;
    end else begin
      r_hold      <= w_hold_nxt;
      r_disp10    <= w_disp_nxt[23:16];
      r_disp1     <= w_disp_nxt[15:8];
      r_disp10ths <= w_disp_nxt[7:0];
    end
  end

  assign d10    = r_disp10;
  assign d1     = r_disp1;
  assign d10ths = r_disp10ths;
`else
  logic w_unused_lap;
  assign w_unused_lap = lap;
  assign w_disp_cur   = {r_cnt10, r_cnt1, r_cnt10ths};
  assign w_disp_nxt   = {w_cnt10_nxt, w_cnt1_nxt, w_cnt10ths_nxt};
  assign d10          = r_cnt10;
  assign d1           = r_cnt1;
  assign d10ths       = r_cnt10ths;
`endif

  assign running = r_running;
  assign upd     = r_upd;
  assign ovf     = r_ovf;

endmodule
